rob_multi: RTL and testbench

Parametrised reorder buffer for the out-of-order core: the next generation of the fixed 16-entry, 4-dispatch, 6-completion ROB. It allocates up to DISPATCH_W entries per cycle in program order and marks entries done from CMPL_W completion ports. It retires up to RETIRE_W consecutive done entries per cycle, returning their old physical registers to the free list. Unlike the previous version, it supports branch-mispredict flush to a tag, and it reports free-entry and overflow status. It sits between rename/dispatch and the free list / architectural commit.

---
 rtl/rob_pkg.sv | 29 ++
 rtl/rob_retire_sel.sv | 31 +++
 rtl/rob_multi.sv | 170 +++++++++++++++++
 tb/tb_rob_multi.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/rob_pkg.sv
// Reorder buffer shared types and helpers.
// Default geometry, entry layout, pointer type and wrap-aware pointer add.
package rob_pkg;

    localparam int ROB_DEPTH     = 16;
    localparam int ROB_TAG_W     = $clog2(ROB_DEPTH);
    localparam int ROB_PAYLOAD_W = 57;
    localparam int ROB_PREG_W    = 6;

    // Pointer with an extra wrap bit above the tag.
    typedef logic [ROB_TAG_W:0] ptr_t;

    typedef struct packed {
        logic                     valid;
        logic                     done;
        logic [ROB_PREG_W-1:0]    old_p;
        logic [ROB_PAYLOAD_W-1:0] payload;
    } rob_entry_t;

    // Modulo add over a pointer of 'bits' width; the top bit is the wrap bit.
    function automatic int unsigned ptr_add(
        input int unsigned p,
        input int unsigned k,
        input int unsigned bits
    );
        return (p + k) & ((32'd1 << bits) - 32'd1);
    endfunction

endpackage

// File: rtl/rob_retire_sel.sv
// Retire selector: length of the ready run starting at head.
// Ports: ready (valid&&done per entry), head tag, occupancy -> count.
module rob_retire_sel
    import rob_pkg::*;
#(
    parameter int DEPTH    = ROB_DEPTH,
    parameter int RETIRE_W = 4,
    parameter int TAG_W    = $clog2(DEPTH)
) (
    input  logic [DEPTH-1:0]                ready,
    input  logic [TAG_W-1:0]                head,
    input  logic [TAG_W:0]                  occ,
    output logic [$clog2(RETIRE_W+1)-1:0]   count
);

    localparam int CW = $clog2(RETIRE_W + 1);

    logic alive;

    // Prefix-AND over the rotated ready vector, stopping at occupancy.
    always_comb begin
        alive = 1'b1;
        count = '0;
        for (int r = 0; r < RETIRE_W; r++) begin
            alive = alive && ready[head + TAG_W'(r)]
                          && (r < int'(occ));
            if (alive) count = count + CW'(1);
        end
    end

endmodule

// File: rtl/rob_multi.sv
// Parametrised reorder buffer: in-order alloc, OoO completion, in-order retire.
// Ports: dispatch lanes/status, completion ports, flush-to-tag, retire lanes.
module rob_multi
    import rob_pkg::*;
#(
    parameter int DEPTH      = ROB_DEPTH,
    parameter int DISPATCH_W = 4,
    parameter int CMPL_W     = 6,
    parameter int RETIRE_W   = 4,
    parameter int PAYLOAD_W  = ROB_PAYLOAD_W,
    parameter int PREG_W     = ROB_PREG_W,
    parameter int TAG_W      = $clog2(DEPTH)
) (
    input  logic                              i_clk,
    input  logic                              i_rst,
    input  logic [$clog2(DISPATCH_W+1)-1:0]   i_ins_count,
    input  logic [DISPATCH_W*PAYLOAD_W-1:0]   i_ins_bundle,
    input  logic [DISPATCH_W*PREG_W-1:0]      i_ins_old_p,
    output logic [TAG_W-1:0]                  o_alloc_tag,
    output logic [TAG_W:0]                    o_free_count,
    output logic                              o_full,
    output logic                              o_empty,
    output logic                              o_overflow,
    input  logic [CMPL_W-1:0]                 i_cmpl_en,
    input  logic [CMPL_W*TAG_W-1:0]           i_cmpl_tag,
    input  logic                              i_flush,
    input  logic [TAG_W-1:0]                  i_flush_tag,
    output logic [$clog2(RETIRE_W+1)-1:0]     o_retire_count,
    output logic [RETIRE_W*PAYLOAD_W-1:0]     o_retire_bundle,
    output logic [RETIRE_W*PREG_W-1:0]        o_retire_old_p
);

    localparam int PTR_W = TAG_W + 1;

    logic [TAG_W:0]   head_q, tail_q, head_nx, tail_nx;
    logic [TAG_W:0]   occ, free;
    logic [TAG_W-1:0] head_idx, tail_idx, fl_dist;
    logic [DEPTH-1:0] valid_q, done_q, valid_nx, done_nx;
    logic             req_ok, fl_hit, accept, ovf_q;

    logic [PREG_W-1:0]    old_p_q   [DEPTH];
    logic [PAYLOAD_W-1:0] payload_q [DEPTH];

    logic [$clog2(RETIRE_W+1)-1:0] ret_n, ret_n_q;
    logic [RETIRE_W*PAYLOAD_W-1:0] ret_bundle_d, ret_bundle_q;
    logic [RETIRE_W*PREG_W-1:0]    ret_old_p_d, ret_old_p_q;

    assign head_idx = head_q[TAG_W-1:0];
    assign tail_idx = tail_q[TAG_W-1:0];
    assign occ      = tail_q - head_q;
    assign free     = PTR_W'(DEPTH) - occ;

    assign o_alloc_tag    = tail_idx;
    assign o_free_count   = free;
    assign o_full         = (occ == PTR_W'(DEPTH));
    assign o_empty        = (occ == '0);
    assign o_overflow     = ovf_q;
    assign o_retire_count = ret_n_q;
    assign o_retire_bundle = ret_bundle_q;
    assign o_retire_old_p  = ret_old_p_q;

    // Space check uses the pre-retire free count.
    assign req_ok = (int'(i_ins_count) <= DISPATCH_W)
                 && (int'(i_ins_count) <= int'(free));
    assign fl_hit  = i_flush && valid_q[i_flush_tag];
    assign accept  = !fl_hit && req_ok;
    // Age of the flush tag relative to head.
    assign fl_dist = i_flush_tag - head_idx;

    rob_retire_sel #(
        .DEPTH    (DEPTH),
        .RETIRE_W (RETIRE_W),
        .TAG_W    (TAG_W)
    ) u_sel (
        .ready (valid_q & done_q),
        .head  (head_idx),
        .occ   (occ),
        .count (ret_n)
    );

    // Order matters: completion, retire, squash, then allocation.
    always_comb begin
        valid_nx = valid_q;
        done_nx  = done_q;
        for (int p = 0; p < CMPL_W; p++) begin
            if (i_cmpl_en[p] && valid_q[i_cmpl_tag[p*TAG_W +: TAG_W]])
                done_nx[i_cmpl_tag[p*TAG_W +: TAG_W]] = 1'b1;
        end
        for (int r = 0; r < RETIRE_W; r++) begin
            if (r < int'(ret_n)) begin
                valid_nx[head_idx + TAG_W'(r)] = 1'b0;
                done_nx[head_idx + TAG_W'(r)]  = 1'b0;
            end
        end
        for (int i = 0; i < DEPTH; i++) begin
            if (fl_hit && ((TAG_W'(i) - head_idx) > fl_dist)) begin
                valid_nx[i] = 1'b0;
                done_nx[i]  = 1'b0;
            end
        end
        if (accept) begin
            for (int k = 0; k < DISPATCH_W; k++) begin
                if (k < int'(i_ins_count)) begin
                    valid_nx[tail_idx + TAG_W'(k)] = 1'b1;
                    done_nx[tail_idx + TAG_W'(k)]  = 1'b0;
                end
            end
        end
    end

    always_comb begin
        head_nx = PTR_W'(ptr_add(32'(head_q), 32'(ret_n), PTR_W));
        tail_nx = tail_q;
        // New tail is rebuilt from head so the wrap bit stays correct.
        if (fl_hit)
            tail_nx = PTR_W'(ptr_add(32'(head_q), 32'(fl_dist) + 32'd1, PTR_W));
        else if (accept)
            tail_nx = PTR_W'(ptr_add(32'(tail_q), 32'(i_ins_count), PTR_W));
    end

    always_comb begin
        ret_bundle_d = '0;
        ret_old_p_d  = '0;
        for (int r = 0; r < RETIRE_W; r++) begin
            if (r < int'(ret_n)) begin
                ret_bundle_d[r*PAYLOAD_W +: PAYLOAD_W] =
                    payload_q[head_idx + TAG_W'(r)];
                ret_old_p_d[r*PREG_W +: PREG_W] =
                    old_p_q[head_idx + TAG_W'(r)];
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            head_q       <= '0;
            tail_q       <= '0;
            valid_q      <= '0;
            done_q       <= '0;
            ret_n_q      <= '0;
            ret_bundle_q <= '0;
            ret_old_p_q  <= '0;
            ovf_q        <= 1'b0;
        end else begin
            head_q       <= head_nx;
            tail_q       <= tail_nx;
            valid_q      <= valid_nx;
            done_q       <= done_nx;
            ret_n_q      <= ret_n;
            ret_bundle_q <= ret_bundle_d;
            ret_old_p_q  <= ret_old_p_d;
            ovf_q        <= !fl_hit && !req_ok;
        end
    end

    // Payload storage has no reset; valid bits gate its use.
    always_ff @(posedge i_clk) begin
        if (accept) begin
            for (int k = 0; k < DISPATCH_W; k++) begin
                if (k < int'(i_ins_count)) begin
                    payload_q[tail_idx + TAG_W'(k)] <=
                        i_ins_bundle[k*PAYLOAD_W +: PAYLOAD_W];
                    old_p_q[tail_idx + TAG_W'(k)] <=
                        i_ins_old_p[k*PREG_W +: PREG_W];
                end
            end
        end
    end

endmodule

// File: tb/tb_rob_multi.sv
// Directed testbench for rob_multi with default parameters.
// Checks alloc, overflow, wrap, multi-port completion, flush and async reset.
module tb_rob_multi;

    localparam int PW = 57;
    localparam int RW = 6;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [2:0]    ins_count = '0;
    logic [227:0]  ins_bundle = '0;
    logic [23:0]   ins_old_p = '0;
    logic [3:0]    alloc_tag;
    logic [4:0]    free_count;
    logic          full, empty, overflow;
    logic [5:0]    cmpl_en = '0;
    logic [23:0]   cmpl_tag = '0;
    logic          flush = 1'b0;
    logic [3:0]    flush_tag = '0;
    logic [2:0]    retire_count;
    logic [227:0]  retire_bundle;
    logic [23:0]   retire_old_p;

    int errors = 0;
    int checks = 0;

    rob_multi dut (
        .i_clk           (clk),
        .i_rst           (rst),
        .i_ins_count     (ins_count),
        .i_ins_bundle    (ins_bundle),
        .i_ins_old_p     (ins_old_p),
        .o_alloc_tag     (alloc_tag),
        .o_free_count    (free_count),
        .o_full          (full),
        .o_empty         (empty),
        .o_overflow      (overflow),
        .i_cmpl_en       (cmpl_en),
        .i_cmpl_tag      (cmpl_tag),
        .i_flush         (flush),
        .i_flush_tag     (flush_tag),
        .o_retire_count  (retire_count),
        .o_retire_bundle (retire_bundle),
        .o_retire_old_p  (retire_old_p)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic disp(input int n, input int base);
        ins_count = 3'(n);
        for (int k = 0; k < 4; k++) begin
            ins_bundle[k*PW +: PW] = PW'(base + k + 256);
            ins_old_p[k*RW +: RW]  = RW'(base + k);
        end
    endtask

    task automatic cmpl(input int n, input int t0);
        cmpl_en = '0;
        for (int p = 0; p < 6; p++) begin
            if (p < n) begin
                cmpl_en[p]         = 1'b1;
                cmpl_tag[p*4 +: 4] = 4'(t0 + p);
            end
        end
    endtask

    task automatic idle();
        ins_count = '0;
        cmpl_en   = '0;
        flush     = 1'b0;
    endtask

    function automatic logic [23:0] oldp_exp(input int n, input int base);
        logic [23:0] v;
        v = '0;
        for (int k = 0; k < 4; k++)
            if (k < n) v[k*RW +: RW] = RW'(base + k);
        return v;
    endfunction

    initial begin
        // Reset state
        #12;
        chk("rst_empty", 64'(empty), 64'd1);
        chk("rst_full", 64'(full), 64'd0);
        chk("rst_free", 64'(free_count), 64'd16);
        chk("rst_tag", 64'(alloc_tag), 64'd0);
        chk("rst_rcount", 64'(retire_count), 64'd0);
        chk("rst_ovf", 64'(overflow), 64'd0);
        rst = 1'b0;

        // Basic alloc / out-of-order completion / retire latency
        disp(4, 20); step(); idle();
        chk("alloc_tag4", 64'(alloc_tag), 64'd4);
        chk("free12", 64'(free_count), 64'd12);
        chk("not_empty", 64'(empty), 64'd0);
        cmpl(3, 1); step(); idle(); step();
        chk("no_retire_gap", 64'(retire_count), 64'd0);
        cmpl(1, 0); step(); idle();
        chk("retire_latency", 64'(retire_count), 64'd0);
        step();
        chk("retire4_cnt", 64'(retire_count), 64'd4);
        chk("retire4_oldp", 64'(retire_old_p), 64'(oldp_exp(4, 20)));
        chk("retire4_pay0", 64'(retire_bundle[0 +: PW]), 64'd276);
        chk("empty_after", 64'(empty), 64'd1);
        step();
        chk("retire_idle", 64'(retire_count), 64'd0);

        // Fill to full then overflow
        disp(4, 0); step();
        disp(4, 4); step();
        disp(4, 8); step();
        disp(4, 12); step();
        chk("full", 64'(full), 64'd1);
        chk("free0", 64'(free_count), 64'd0);
        chk("full_tag", 64'(alloc_tag), 64'd4);
        disp(1, 99); step(); idle();
        chk("ovf_pulse", 64'(overflow), 64'd1);
        chk("ovf_tail", 64'(alloc_tag), 64'd4);
        chk("ovf_full", 64'(full), 64'd1);
        step();
        chk("ovf_clear", 64'(overflow), 64'd0);

        // Six completions, retire capped at four per cycle
        cmpl(6, 4); step(); idle(); step();
        chk("six_a_cnt", 64'(retire_count), 64'd4);
        chk("six_a_oldp", 64'(retire_old_p), 64'(oldp_exp(4, 0)));
        chk("six_a_pay3", 64'(retire_bundle[3*PW +: PW]), 64'd259);
        step();
        chk("six_b_cnt", 64'(retire_count), 64'd2);
        chk("six_b_oldp", 64'(retire_old_p), 64'(oldp_exp(2, 4)));
        chk("six_b_pay2", 64'(retire_bundle[2*PW +: PW]), 64'd0);
        step();
        chk("six_c_cnt", 64'(retire_count), 64'd0);
        cmpl(6, 10); step();
        cmpl(4, 0); step(); idle();
        repeat (5) step();
        chk("drain_empty", 64'(empty), 64'd1);
        chk("drain_tag", 64'(alloc_tag), 64'd4);

        // Move head to 14, then dispatch across the wrap
        disp(4, 70); step();
        disp(4, 74); step();
        disp(2, 78); step(); idle();
        cmpl(6, 4); step();
        cmpl(4, 10); step(); idle();
        repeat (5) step();
        chk("head14_empty", 64'(empty), 64'd1);
        chk("head14_tag", 64'(alloc_tag), 64'd14);
        disp(4, 30); step(); idle();
        chk("wrap_tag", 64'(alloc_tag), 64'd2);
        chk("wrap_free", 64'(free_count), 64'd12);
        cmpl(4, 14); step(); idle(); step();
        chk("wrap_cnt", 64'(retire_count), 64'd4);
        chk("wrap_oldp", 64'(retire_old_p), 64'(oldp_exp(4, 30)));
        chk("wrap_pay3", 64'(retire_bundle[3*PW +: PW]), 64'd289);
        chk("wrap_empty", 64'(empty), 64'd1);

        // Asynchronous reset mid-stream
        disp(3, 60); step(); idle();
        cmpl(1, 2); step(); idle(); step();
        chk("pre_rst_cnt", 64'(retire_count), 64'd1);
        chk("pre_rst_oldp", 64'(retire_old_p), 64'(oldp_exp(1, 60)));
        #2 rst = 1'b1;
        #1;
        chk("arst_empty", 64'(empty), 64'd1);
        chk("arst_free", 64'(free_count), 64'd16);
        chk("arst_tag", 64'(alloc_tag), 64'd0);
        chk("arst_cnt", 64'(retire_count), 64'd0);
        chk("arst_oldp", 64'(retire_old_p), 64'd0);
        rst = 1'b0;

        // Flush beats a same-cycle dispatch
        disp(4, 40); step();
        disp(4, 44); step(); idle();
        chk("pre_fl_free", 64'(free_count), 64'd8);
        chk("pre_fl_tag", 64'(alloc_tag), 64'd8);
        flush = 1'b1;
        flush_tag = 4'd3;
        disp(2, 90);
        cmpl(1, 5);
        step(); idle();
        chk("fl_tag", 64'(alloc_tag), 64'd4);
        chk("fl_free", 64'(free_count), 64'd12);
        chk("fl_no_ovf", 64'(overflow), 64'd0);
        cmpl(1, 5); step(); idle();
        disp(2, 50); step(); idle();
        chk("post_fl_tag", 64'(alloc_tag), 64'd6);
        cmpl(5, 0); step(); idle(); step();
        chk("fl_ret_cnt", 64'(retire_count), 64'd4);
        chk("fl_ret_oldp", 64'(retire_old_p), 64'(oldp_exp(4, 40)));
        step();
        chk("fl_ret1_cnt", 64'(retire_count), 64'd1);
        chk("fl_ret1_oldp", 64'(retire_old_p), 64'(oldp_exp(1, 50)));
        cmpl(1, 5); step(); idle(); step();
        chk("fl_last_cnt", 64'(retire_count), 64'd1);
        chk("fl_last_oldp", 64'(retire_old_p), 64'(oldp_exp(1, 51)));
        chk("fl_empty", 64'(empty), 64'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
